// File: rtl/dmi_access_ctrl.sv
// DMI access sequencer: turns one decoded DTM dmi scan word into a single DMI
// request/response transaction and holds the read data plus a sticky status.
package dm;
  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_access_ctrl #(
  parameter int unsigned AbitsWidth  = 7,
  parameter int unsigned RespTimeout = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmi_clear_i,
  input  logic                  update_i,
  input  logic [1:0]            op_i,
  input  logic [AbitsWidth-1:0] addr_i,
  input  logic [31:0]           data_i,
  input  logic                  capture_i,
  output logic [AbitsWidth-1:0] result_addr_o,
  output logic [31:0]           result_data_o,
  output logic [1:0]            result_status_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output dm::dmi_req_t          dmi_req_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  dm::dmi_resp_t         dmi_resp_i
);

  localparam int unsigned TmoW = (RespTimeout > 1) ? $clog2(RespTimeout) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RespTimeout - 1);

  typedef enum logic [2:0] {
    Idle           = 3'd0,
    Read           = 3'd1,
    Write          = 3'd2,
    WaitReadValid  = 3'd3,
    WaitWriteValid = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [AbitsWidth-1:0] addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          err_q, err_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                req_valid_q, req_valid_d;
  logic                resp_ready_q, resp_ready_d;
  dm::dtm_op_e         req_op_q, req_op_d;
  logic                set_busy, set_fail;

  // Next-state, datapath and sticky-error computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    set_busy  = 1'b0;
    set_fail  = 1'b0;

    case (state_q)
      Idle: begin
        if (update_i && (err_q == 2'd0)) begin
          if (op_i == dm::DTM_READ) begin
            addr_d  = addr_i;
            state_d = Read;
          end else if (op_i == dm::DTM_WRITE) begin
            addr_d  = addr_i;
            data_d  = data_i;
            state_d = Write;
          end else begin
            state_d = Idle;
          end
        end else begin
          state_d = Idle;
        end
      end
      Read, Write: begin
        if (dmi_req_ready_i) begin
          state_d   = (state_q == Read) ? WaitReadValid : WaitWriteValid;
          tmo_cnt_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      WaitReadValid, WaitWriteValid: begin
        // A response in the final timeout cycle still completes normally.
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (state_q == WaitReadValid) begin
            data_d = dmi_resp_i.data;
          end else begin
            data_d = data_q;
          end
          if (dmi_resp_i.resp != 2'd0) begin
            set_fail = 1'b1;
          end else begin
            set_fail = 1'b0;
          end
        end else if ((RespTimeout != 0) && (tmo_cnt_q == TmoLast)) begin
          state_d  = Idle;
          set_fail = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      default: state_d = Idle;
    endcase

    if ((update_i || capture_i) && (state_q != Idle)) begin
      set_busy = 1'b1;
    end else begin
      set_busy = 1'b0;
    end

    if (dmi_clear_i) begin
      err_d = 2'd0;
    end else if (err_q == 2'd0) begin
      if (set_busy) begin
        err_d = 2'd3;
      end else if (set_fail) begin
        err_d = 2'd2;
      end else begin
        err_d = 2'd0;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Output decode from the next state so the DMI handshake signals are flops.
  always_comb begin
    req_valid_d  = (state_d == Read) || (state_d == Write);
    resp_ready_d = !req_valid_d;
    case (state_d)
      Read:    req_op_d = dm::DTM_READ;
      Write:   req_op_d = dm::DTM_WRITE;
      default: req_op_d = dm::DTM_NOP;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      addr_q       <= '0;
      data_q       <= 32'h0000_0000;
      err_q        <= 2'd0;
      tmo_cnt_q    <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
      req_op_q     <= dm::DTM_NOP;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      req_op_q     <= req_op_d;
    end
  end

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_req_o        = {addr_q, req_op_q, data_q};
  assign result_addr_o    = addr_q;
  assign result_data_o    = data_q;
  assign result_status_o  = (state_q != Idle) ? 2'd3 : err_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Scoreboard bench for dmi_access_ctrl: expected DMI requests and capture
// results are queued by the stimulus and checked by independent monitors.
module tb_dmi_access_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dmi_clear = 1'b0;
  logic          update = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [6:0]    addr = 7'h00;
  logic [31:0]   data = 32'h0;
  logic          capture = 1'b0;
  logic [6:0]    res_addr;
  logic [31:0]   res_data;
  logic [1:0]    res_status;
  logic          req_valid;
  logic          req_ready = 1'b1;
  dm::dmi_req_t  dmi_req;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  dm::dmi_resp_t dmi_resp = '0;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    int          cycles;
  } req_exp_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    logic [6:0]  addr;
  } res_exp_t;

  req_exp_t req_q[$];
  res_exp_t res_q[$];

  dmi_access_ctrl #(.AbitsWidth(7), .RespTimeout(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmi_clear_i(dmi_clear),
    .update_i(update), .op_i(op), .addr_i(addr), .data_i(data),
    .capture_i(capture), .result_addr_o(res_addr), .result_data_o(res_data),
    .result_status_o(res_status), .dmi_req_valid_o(req_valid),
    .dmi_req_ready_i(req_ready), .dmi_req_o(dmi_req),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_i(dmi_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [1:0] o, input logic [6:0] a, input logic [31:0] d);
    update = 1'b1; op = o; addr = a; data = d;
    tick();
    update = 1'b0; op = 2'd0; addr = 7'h00; data = 32'h0;
  endtask

  task automatic do_capture(input logic [1:0] st, input logic [31:0] d, input logic [6:0] a);
    res_exp_t e;
    e.st = st; e.data = d; e.addr = a;
    res_q.push_back(e);
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic push_req(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d, input int c);
    req_exp_t e;
    e.addr = a; e.op = o; e.data = d; e.cycles = c;
    req_q.push_back(e);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    resp_valid = 1'b1; dmi_resp.data = d; dmi_resp.resp = r;
    tick();
    resp_valid = 1'b0; dmi_resp = '0;
  endtask

  task automatic clear_pulse();
    dmi_clear = 1'b1;
    tick();
    dmi_clear = 1'b0;
  endtask

  // Request monitor: payload stability, valid duration and request count.
  always @(negedge clk) begin
    if (!rst_n) begin
      vcnt = 0;
    end else if (req_valid) begin
      vcnt++;
      if (req_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_req: got addr=0x%0h op=%0d expected no request", dmi_req.addr, dmi_req.op);
      end else begin
        check("req_payload", 64'(dmi_req), {23'h0, req_q[0].addr, req_q[0].op, req_q[0].data});
        if (req_ready) begin
          check("req_valid_cycles", 64'(vcnt), 64'(req_q[0].cycles));
          void'(req_q.pop_front());
          vcnt = 0;
        end
      end
    end
  end

  // Capture monitor: compares what the DTM would sample.
  always @(negedge clk) begin
    if (rst_n && capture) begin
      if (res_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_capture: got status=%0d expected queued result", res_status);
      end else begin
        check("cap_status", 64'(res_status), 64'(res_q[0].st));
        check("cap_data", 64'(res_data), 64'(res_q[0].data));
        check("cap_addr", 64'(res_addr), 64'(res_q[0].addr));
        void'(res_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(req_valid), 64'd0);
    check("rst_resp_ready", 64'(resp_ready), 64'd1);
    check("rst_status", 64'(res_status), 64'd0);
    check("rst_data", 64'(res_data), 64'd0);
    check("rst_addr", 64'(res_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Read with immediate ready and response: 3-cycle latency
    push_req(7'h11, 2'd1, 32'h0000_0000, 1);
    do_update(2'd1, 7'h11, 32'h0);
    tick();
    check("t1_busy_in_wait", 64'(res_status), 64'd3);
    respond(32'hDEAD_BEEF, 2'd0);
    check("t1_idle_latency", 64'(res_status), 64'd0);
    do_capture(2'd0, 32'hDEAD_BEEF, 7'h11);

    // Write held off by 5 cycles of backpressure
    req_ready = 1'b0;
    push_req(7'h04, 2'd2, 32'hA5A5_A5A5, 6);
    do_update(2'd2, 7'h04, 32'hA5A5_A5A5);
    check("t2_resp_ready_low", 64'(resp_ready), 64'd0);
    repeat (5) tick();
    req_ready = 1'b1;
    tick();
    respond(32'h1234_5678, 2'd0);
    do_capture(2'd0, 32'hA5A5_A5A5, 7'h04);

    // Busy: update and capture while waiting on the response
    push_req(7'h22, 2'd1, 32'hA5A5_A5A5, 1);
    do_update(2'd1, 7'h22, 32'h0);
    tick();
    do_update(2'd1, 7'h33, 32'h0);
    do_capture(2'd3, 32'hA5A5_A5A5, 7'h22);
    respond(32'h0BAD_F00D, 2'd0);
    do_capture(2'd3, 32'h0BAD_F00D, 7'h22);
    do_update(2'd2, 7'h44, 32'h1111_1111);
    repeat (2) tick();
    do_capture(2'd3, 32'h0BAD_F00D, 7'h22);
    clear_pulse();
    do_capture(2'd0, 32'h0BAD_F00D, 7'h22);
    push_req(7'h55, 2'd1, 32'h0BAD_F00D, 1);
    do_update(2'd1, 7'h55, 32'h0);
    tick();
    respond(32'h600D_CAFE, 2'd0);
    do_capture(2'd0, 32'h600D_CAFE, 7'h55);

    // Error response is sticky and blocks further requests
    push_req(7'h10, 2'd1, 32'h600D_CAFE, 1);
    do_update(2'd1, 7'h10, 32'h0);
    tick();
    respond(32'hFFFF_0000, 2'd2);
    for (int i = 0; i < 3; i++) begin
      do_update(2'd1, 7'h20 + 7'(i), 32'h0);
      tick();
      do_capture(2'd2, 32'hFFFF_0000, 7'h10);
    end
    clear_pulse();
    do_capture(2'd0, 32'hFFFF_0000, 7'h10);

    // Timeout after 8 cycles in WaitReadValid, then a late response is drained
    push_req(7'h2A, 2'd1, 32'hFFFF_0000, 1);
    do_update(2'd1, 7'h2A, 32'h0);
    tick();
    repeat (7) tick();
    check("t5_still_waiting", 64'(res_status), 64'd3);
    tick();
    check("t5_timeout_status", 64'(res_status), 64'd2);
    check("t5_drain_ready", 64'(resp_ready), 64'd1);
    respond(32'h9999_9999, 2'd0);
    do_capture(2'd2, 32'hFFFF_0000, 7'h2A);
    clear_pulse();

    // Asynchronous reset in the middle of a write
    req_ready = 1'b0;
    push_req(7'h7F, 2'd2, 32'h1357_2468, 0);
    do_update(2'd2, 7'h7F, 32'h1357_2468);
    tick();
    check("t6_valid_before", 64'(req_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid_async", 64'(req_valid), 64'd0);
    check("t6_status", 64'(res_status), 64'd0);
    check("t6_addr", 64'(res_addr), 64'd0);
    check("t6_data", 64'(res_data), 64'd0);
    req_q.delete();
    req_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    do_capture(2'd0, 32'h0, 7'h00);

    repeat (2) tick();
    check("req_queue_empty", 64'(req_q.size()), 64'd0);
    check("res_queue_empty", 64'(res_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
